piso_stream: RTL and testbench
==============================

Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out serializer; successor to the 4-bit load/shift PISO.
- Adds generic width, selectable bit order, valid/ready load handshake, clock-enable stall, frame-end marker and gapless back-to-back frames.
- Sits between a parallel word source (register file, FIFO pop side) and a single-wire serial sink (UART-style or bit-banged link).

Parameters:
- WIDTH, 8, parallel word width in bits; legal range 2..64.
- LSB_FIRST, 0, 0 = transmit pin[WIDTH-1] first; 1 = transmit pin[0] first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  clock enable; low freezes all state and outputs.
- load  input  1  source offers pin this cycle (valid).
- pin  input  WIDTH  parallel word; sampled only on an accepted load.
- ready  output  1  block accepts load this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a frame bit this cycle.
- last  output  1  sout is the final bit of the current frame.

Behaviour:
- Reset (rst=1 at the edge; overrides en and load): state=IDLE, shift register=0, bit counter=0, sout=0, sout_valid=0, last=0. ready is then 1 whenever en=1.
- FSM states: IDLE and SHIFT.
- ready = en & (state==IDLE | (state==SHIFT & last)); combinational.
- Accept = load & ready at a rising edge. pin is captured and state goes to SHIFT. The first frame bit appears on sout with sout_valid=1 in the next cycle (latency 1 cycle).
- SHIFT:
  - Each enabled edge presents the next bit and increments the counter. Counter width is $clog2(FRAME_LEN+1).
  - FRAME_LEN = WIDTH (WIDTH+1 with the parity option).
  - last=1 exactly while the final frame bit is on sout.
- End of frame (edge where last=1, en=1):
  - If load=1: the new word is captured and its first bit appears in the next cycle. No idle gap, and sout_valid stays 1.
  - Otherwise: state goes to IDLE, and sout, sout_valid and last return to 0.
- IDLE: sout=0, sout_valid=0, last=0.
- en=0: no state update, outputs held, ready=0, load ignored. A frame resumes on the same bit when en returns to 1.
- load while ready=0: ignored. It is not queued, and pin is not sampled.
- Reset mid-frame: the frame is aborted with no partial last. Reset values hold from the next cycle.
- Bit order is fixed at capture. Changing pin during SHIFT has no effect.

Optional Feature:
- Macro: PISO_STREAM_PARITY_EN.
- Defined: each frame is WIDTH data bits followed by one even-parity bit (XOR of the captured word). last is asserted on the parity bit and sout_valid=1 for it. FRAME_LEN = WIDTH+1.
- Undefined: FRAME_LEN = WIDTH, and no parity logic is synthesised.

Decomposition:
- Package piso_stream_pkg holds:
  - the state typedef (IDLE, SHIFT);
  - a function returning the counter width for a given frame length.
- One sub-module, piso_bit_cnt: parametrised up-counter with synchronous clear, enable and terminal-count flag. It drives last and the FSM exit.
- The shift register and FSM stay in piso_stream.

Test Plan:
- WIDTH=4, LSB_FIRST=0, rst high 1 cycle, en=1, load=1 with pin=4'b1011 for 1 cycle -> sout 1,0,1,1 on the next 4 cycles; sout_valid=1 for all 4; last only on the 4th; then IDLE with ready=1.
- WIDTH=8, LSB_FIRST=1, pin=8'hA5 -> sout 1,0,1,0,0,1,0,1; ready=0 for the first 7 bits.
- Back-to-back, WIDTH=4: 4'b1100, with load held high and pin changed to 4'b0011 during the last bit -> sout 1,1,0,0,0,0,1,1 with no gap; sout_valid continuous for 8 cycles; last on bits 4 and 8.
- Stall, WIDTH=8, pin=8'hF0, en=0 for 3 cycles after bit 2 -> sout, sout_valid and last frozen and ready=0 during the stall; full sequence 1,1,1,1,0,0,0,0 completes after en=1.
- Reset mid-frame: pin=8'h81 with rst pulsed during bit 3 -> next cycle sout_valid=0, last=0, ready=1; a new load of 8'h01 then serialises cleanly as 0,0,0,0,0,0,0,1.
- PISO_STREAM_PARITY_EN defined, WIDTH=4, pin=4'b1011 -> sout 1,0,1,1,1 with last on the 5th bit; pin=4'b1001 -> parity bit 0.

Source files
------------

// File: rtl/piso_stream_pkg.sv
// Shared definitions for the piso_stream serializer: FSM state encoding
// and the bit-counter width helper.
package piso_stream_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE  = 1'b0;
  localparam state_t SHIFT = 1'b1;

  // Counter must be able to hold values 0..frame_len.
  function automatic int cnt_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Frame bit counter for piso_stream: synchronous clear (wins over
// increment), increment enable, and a terminal-count flag that marks the
// final frame bit.
module piso_bit_cnt #(
  parameter int CW = 4,
  parameter int TC = 7
) (
  input  logic clk,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [CW-1:0] cnt;

  // Count presented bits; cleared at reset, on every new frame and at frame end.
  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (inc)
      cnt <= cnt + CW'(1);
  end

  assign tc = (cnt == CW'(TC));

endmodule

// File: rtl/piso_stream.sv
// Parameterised parallel-in/serial-out serializer with valid/ready load,
// clock-enable stall, frame-end marker and gapless back-to-back frames.
// Optional even-parity bit appended to each frame when the macro
// PISO_STREAM_PARITY_EN is defined.
module piso_stream
  import piso_stream_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] pin,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last
);

`ifdef PISO_STREAM_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = cnt_width(FRAME_LEN);

  state_t               state;
  logic [FRAME_LEN-1:0] frame;
  logic [FRAME_LEN-1:0] sreg;
  logic                 tc;
  logic                 accept;
  logic                 frame_end;
  logic                 shift_step;

  // Arrange the captured word so the first bit to send sits at the end the
  // shifter drains from; the parity bit always goes out last.
  always_comb begin
`ifdef PISO_STREAM_PARITY_EN
    frame = LSB_FIRST ? {^pin, pin} : {pin, ^pin};
`else
    frame = pin;
`endif
  end

  assign last       = (state == SHIFT) & tc;
  assign ready      = en & ((state == IDLE) | last);
  assign accept     = load & ready;
  assign frame_end  = en & last;
  assign shift_step = en & (state == SHIFT) & ~tc;

  piso_bit_cnt #(
    .CW (CW),
    .TC (FRAME_LEN - 1)
  ) u_bit_cnt (
    .clk (clk),
    .clr (rst | accept | frame_end),
    .inc (shift_step),
    .tc  (tc)
  );

  // FSM and shifter: a load (including one on the last bit) wins over frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
    end else if (accept) begin
      state      <= SHIFT;
      sout_valid <= 1'b1;
      if (LSB_FIRST) begin
        sout <= frame[0];
        sreg <= frame >> 1;
      end else begin
        sout <= frame[FRAME_LEN-1];
        sreg <= frame << 1;
      end
    end else if (frame_end) begin
      state      <= IDLE;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
    end else if (shift_step) begin
      if (LSB_FIRST) begin
        sout <= sreg[0];
        sreg <= sreg >> 1;
      end else begin
        sout <= sreg[FRAME_LEN-1];
        sreg <= sreg << 1;
      end
    end
  end

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: three instances (4-bit MSB-first, 8-bit MSB-first,
// 8-bit LSB-first) share one stimulus; a frame-list model predicts every
// output each cycle, and directed sequences are pinned to literal bit strings.
module tb_piso_stream;

`ifdef PISO_STREAM_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL4 = 4 + PAR;
  localparam int FL8 = 8 + PAR;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [7:0] pin;
  logic [2:0] so, sv, la, rd;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  piso_stream #(.WIDTH(4), .LSB_FIRST(1'b0)) d4 (
    .clk(clk), .rst(rst), .en(en), .load(load), .pin(pin[3:0]),
    .ready(rd[0]), .sout(so[0]), .sout_valid(sv[0]), .last(la[0]));
  piso_stream #(.WIDTH(8), .LSB_FIRST(1'b0)) d8m (
    .clk(clk), .rst(rst), .en(en), .load(load), .pin(pin),
    .ready(rd[1]), .sout(so[1]), .sout_valid(sv[1]), .last(la[1]));
  piso_stream #(.WIDTH(8), .LSB_FIRST(1'b1)) d8l (
    .clk(clk), .rst(rst), .en(en), .load(load), .pin(pin),
    .ready(rd[2]), .sout(so[2]), .sout_valid(sv[2]), .last(la[2]));

  function automatic int wof(input int d);
    return (d == 0) ? 4 : 8;
  endfunction

  function automatic bit lof(input int d);
    return (d == 2);
  endfunction

  // Frame as a list: element i is the i-th bit put on the wire.
  function automatic logic [15:0] build(input int w, input bit lsb, input logic [7:0] p);
    logic [15:0] f;
    logic        par;
    f   = '0;
    par = 1'b0;
    for (int i = 0; i < w; i++) begin
      f[i] = lsb ? p[i] : p[w-1-i];
      par  = par ^ p[i];
    end
    if (PAR == 1) f[w] = par;
    return f;
  endfunction

  // Model: current frame list, index of the bit on the wire, frame length (0 = idle).
  logic [15:0] mfr [3];
  int          mpos [3] = '{0, 0, 0};
  int          mlen [3] = '{0, 0, 0};

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        mlen[d] <= 0;
        mpos[d] <= 0;
      end else if (en) begin
        if (load && (mpos[d] >= mlen[d] - 1)) begin
          mfr[d]  <= build(wof(d), lof(d), pin);
          mlen[d] <= wof(d) + PAR;
          mpos[d] <= 0;
        end else if (mpos[d] < mlen[d]) begin
          if (mpos[d] + 1 == mlen[d]) begin
            mlen[d] <= 0;
            mpos[d] <= 0;
          end else begin
            mpos[d] <= mpos[d] + 1;
          end
        end
      end
    end
  end

  function automatic logic e_valid(input int d);
    return mpos[d] < mlen[d];
  endfunction

  function automatic logic e_sout(input int d);
    return e_valid(d) ? mfr[d][mpos[d]] : 1'b0;
  endfunction

  function automatic logic e_last(input int d);
    return e_valid(d) && (mpos[d] == mlen[d] - 1);
  endfunction

  function automatic logic e_ready(input int d);
    return en && (mpos[d] >= mlen[d] - 1);
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 3; d++) begin
        check($sformatf("d%0d_sout", d),  16'(so[d]), 16'(e_sout(d)));
        check($sformatf("d%0d_valid", d), 16'(sv[d]), 16'(e_valid(d)));
        check($sformatf("d%0d_last", d),  16'(la[d]), 16'(e_last(d)));
        check($sformatf("d%0d_ready", d), 16'(rd[d]), 16'(e_ready(d)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sv !== 3'b000 && n < 40) begin
      tick();
      n++;
    end
    check("idle_timeout", 16'(sv === 3'b000), 16'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    logic        vv;
    int          nl;

    rst = 1'b1; en = 1'b1; load = 1'b0; pin = 8'h00;
    tick();
    rst = 1'b0;
    started = 1'b1;

    // Model pinned to hand-derived frame lists.
    check("model_msb", build(4, 1'b0, 8'h0B) & 16'h000F, 16'h000D);
    check("model_lsb", build(8, 1'b1, 8'hA5) & 16'h00FF, 16'h00A5);

    // Reset state.
    @(negedge clk);
    check("rst_ready", 16'(rd[0]), 16'd1);
    check("rst_valid", 16'(sv),    16'd0);
    check("rst_last",  16'(la),    16'd0);
    check("rst_sout",  16'(so),    16'd0);
    tick();

    // 4-bit MSB-first 1011.
    pin = 8'h0B; load = 1'b1;
    tick();
    load = 1'b0;
    v = '0;
    for (int i = 0; i < FL4; i++) begin
      @(negedge clk);
      v = {v[14:0], so[0]};
      tick();
    end
    check("a_bits", v, (PAR == 1) ? 16'b10111 : 16'b1011);
    @(negedge clk);
    check("a_idle_ready", 16'(rd[0]), 16'd1);
    check("a_idle_valid", 16'(sv[0]), 16'd0);
    tick();
    wait_idle();

    // 8-bit LSB-first A5; not ready while a non-final bit is out.
    pin = 8'hA5; load = 1'b1;
    tick();
    load = 1'b0;
    v = '0;
    for (int i = 0; i < FL8; i++) begin
      @(negedge clk);
      v = {v[14:0], so[2]};
      if (i < 7) check("b_ready", 16'(rd[2]), 16'd0);
      tick();
    end
    check("b_bits", v, (PAR == 1) ? 16'b101001010 : 16'b10100101);
    wait_idle();

    // Back-to-back on the 4-bit instance, new word offered during the last bit.
    pin = 8'h0C; load = 1'b1;
    tick();
    v = '0; vv = 1'b1; nl = 0;
    for (int i = 0; i < 2 * FL4; i++) begin
      if (i == FL4 - 1) pin = 8'h03;
      if (i == FL4) load = 1'b0;
      @(negedge clk);
      v  = {v[14:0], so[0]};
      vv = vv & sv[0];
      if (la[0]) nl++;
      tick();
    end
    load = 1'b0;
    check("btb_bits", v, (PAR == 1) ? 16'b1100000110 : 16'b11000011);
    check("btb_valid", 16'(vv), 16'd1);
    check("btb_lasts", 16'(nl), 16'd2);
    wait_idle();

    // Stall after bit 2 on the 8-bit MSB-first instance.
    pin = 8'hF0; load = 1'b1;
    tick();
    load = 1'b0;
    v = '0;
    @(negedge clk);
    v = {v[14:0], so[1]};
    tick();
    en = 1'b0;
    @(negedge clk);
    v = {v[14:0], so[1]};
    for (int s = 0; s < 3; s++) begin
      tick();
      if (s == 2) en = 1'b1;
      @(negedge clk);
      check("stall_sout",  16'(so[1]), 16'd1);
      check("stall_valid", 16'(sv[1]), 16'd1);
      check("stall_last",  16'(la[1]), 16'd0);
      if (s < 2) check("stall_ready", 16'(rd[1]), 16'd0);
    end
    tick();
    for (int i = 2; i < FL8; i++) begin
      @(negedge clk);
      v = {v[14:0], so[1]};
      tick();
    end
    check("stall_bits", v, (PAR == 1) ? 16'b111100000 : 16'b11110000);
    wait_idle();

    // Reset while bit 3 of 81 is on the wire, then a clean 01 frame.
    pin = 8'h81; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 16'(sv[1]), 16'd0);
    check("mid_rst_last",  16'(la[1]), 16'd0);
    check("mid_rst_ready", 16'(rd[1]), 16'd1);
    tick();
    pin = 8'h01; load = 1'b1;
    tick();
    load = 1'b0;
    v = '0;
    for (int i = 0; i < FL8; i++) begin
      @(negedge clk);
      v = {v[14:0], so[1]};
      tick();
    end
    check("after_rst_bits", v, (PAR == 1) ? 16'b000000011 : 16'b00000001);
    wait_idle();

    // 4-bit 1001 (even parity bit is 0).
    pin = 8'h09; load = 1'b1;
    tick();
    load = 1'b0;
    v = '0;
    for (int i = 0; i < FL4; i++) begin
      @(negedge clk);
      v = {v[14:0], so[0]};
      tick();
    end
    check("c_bits", v, (PAR == 1) ? 16'b10010 : 16'b1001);
    wait_idle();

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 59) == 0);
      en   = ($urandom_range(0, 4) != 0);
      load = ($urandom_range(0, 1) == 1);
      pin  = 8'($urandom);
      tick();
    end
    rst = 1'b0; en = 1'b1; load = 1'b0;
    wait_idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
